fib_core_arbiter: RTL and testbench

FIB_CORE_ARBITER -- requirements
Module: fib_core_arbiter

---
 rtl/fib_core_arbiter.sv | 141 ++++++++++++++
 tb/tb_fib_core_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fib_core_arbiter.sv
// Round-robin arbiter that shares one iterative core between NREQ requesters.
// One job in flight: accept -> load core -> wait for done or timeout -> respond.
module fib_core_arbiter #(
  parameter int NREQ    = 4,
  parameter int W       = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_n,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic [NREQ-1:0]   rsp_valid,
  input  logic [NREQ-1:0]   rsp_ready,
  output logic [W-1:0]      rsp_data,
  output logic              rsp_err,
  output logic              core_r_enable,
  output logic [W-1:0]      core_init_n,
  output logic [W-1:0]      core_init_a,
  output logic [W-1:0]      core_init_b,
  input  logic              core_w_enable,
  input  logic [W-1:0]      core_result,
  output logic              busy
);
  localparam int PW = $clog2(NREQ);
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [PW:0]     NREQ_W = (PW+1)'(NREQ);
  localparam logic [NREQ-1:0] ONE    = NREQ'(1);
  localparam logic [CW-1:0]   CNT_MAX = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, RESP} state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d, g_q, g_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  op_n_q, op_n_d, op_a_q, op_a_d, op_b_q, op_b_d;
  logic [W-1:0]  rsp_data_q, rsp_data_d;
  logic          rsp_err_q, rsp_err_d;

  // Rotate so bit 0 is the requester at ptr; the lowest set bit is the grant offset.
  logic [2*NREQ-1:0] rot;
  logic [PW-1:0]     off, pick;
  logic [PW:0]       sum;
  logic              any_vld;

  assign rot = {req_valid, req_valid} >> ptr_q;

  always_comb begin
    any_vld = 1'b0;
    off     = '0;
    for (int k = NREQ-1; k >= 0; k--) begin
      if (rot[k]) begin
        any_vld = 1'b1;
        off     = PW'(k);
      end
    end
  end

  assign sum  = {1'b0, ptr_q} + {1'b0, off};
  assign pick = (sum >= NREQ_W) ? PW'(sum - NREQ_W) : PW'(sum);

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    g_d        = g_q;
    cnt_d      = cnt_q;
    op_n_d     = op_n_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    case (state_q)
      IDLE: if (any_vld) begin
        op_n_d  = req_n[pick*W +: W];
        op_a_d  = req_a[pick*W +: W];
        op_b_d  = req_b[pick*W +: W];
        g_d     = pick;
        state_d = LOAD;
      end
      LOAD: begin
        cnt_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        // Done wins over a timeout landing in the same cycle.
        if (core_w_enable) begin
          rsp_data_d = core_result;
          rsp_err_d  = 1'b0;
          state_d    = RESP;
        end else if (cnt_q == CNT_MAX) begin
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
          state_d    = RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESP: if (rsp_ready[g_q]) begin
        ptr_d   = (g_q == PW'(NREQ - 1)) ? '0 : g_q + PW'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      g_q        <= '0;
      cnt_q      <= '0;
      op_n_q     <= '0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      g_q        <= g_d;
      cnt_q      <= cnt_d;
      op_n_q     <= op_n_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  assign req_ready     = (state_q == IDLE && any_vld) ? (ONE << pick) : '0;
  assign rsp_valid     = (state_q == RESP) ? (ONE << g_q) : '0;
  assign rsp_data      = rsp_data_q;
  assign rsp_err       = rsp_err_q;
  assign core_r_enable = (state_q == LOAD);
  assign core_init_n   = op_n_q;
  assign core_init_a   = op_a_q;
  assign core_init_b   = op_b_q;
  assign busy          = (state_q != IDLE);
endmodule

// File: tb/tb_fib_core_arbiter.sv
// Scoreboard bench: a transaction-level model predicts grants and responses,
// a negedge monitor compares them against the arbiter driving a stub core.
module tb_fib_core_arbiter;
  localparam int NREQ = 4;
  localparam int W = 32;
  localparam int TIMEOUT = 16;

  logic clk = 1'b0;
  logic rst_n;
  logic [NREQ-1:0] req_valid, req_ready, rsp_valid, rsp_ready;
  logic [NREQ*W-1:0] req_n, req_a, req_b;
  logic [W-1:0] rsp_data, core_init_n, core_init_a, core_init_b;
  logic rsp_err, core_r_enable, busy;
  logic core_w_enable = 1'b0;
  logic [W-1:0] core_result = '0;

  fib_core_arbiter #(.NREQ(NREQ), .W(W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_n(req_n), .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .core_r_enable(core_r_enable), .core_init_n(core_init_n),
    .core_init_a(core_init_a), .core_init_b(core_init_b),
    .core_w_enable(core_w_enable), .core_result(core_result), .busy(busy));

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic tmo(input string nm);
    checks++;
    failures++;
    $display("FAIL %s wait bound expired", nm);
  endtask

  // Core behaviour: x,y <- y,x+y repeated n mod 64 times, result x.
  function automatic logic [31:0] fib(input logic [31:0] n, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] x, y, t;
    x = a;
    y = b;
    for (int i = 0; i < int'(n[5:0]); i++) begin
      t = x + y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  function automatic int rr_pick(input logic [NREQ-1:0] v, input int p);
    for (int k = 0; k < NREQ; k++)
      if (v[(p + k) % NREQ]) return (p + k) % NREQ;
    return 0;
  endfunction

  function automatic logic [NREQ-1:0] onehot(input int i);
    logic [NREQ-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Stub core: done level rises delay_cfg cycles after the load pulse, held until next load.
  int delay_cfg = 1;
  int stub_rem = 0;
  always @(posedge clk) begin
    if (core_r_enable) begin
      core_result   <= fib(core_init_n, core_init_a, core_init_b);
      stub_rem      <= delay_cfg - 1;
      core_w_enable <= (delay_cfg == 1);
    end else if (stub_rem > 0) begin
      stub_rem <= stub_rem - 1;
      if (stub_rem == 1) core_w_enable <= 1'b1;
    end
  end

  typedef struct {
    int g;
    logic [31:0] data;
    logic err;
    longint acc;
    longint lat;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur, e;
  logic [NREQ-1:0] dut_glog[$];
  logic [NREQ-1:0] acc_mask = '0;
  logic m_busy = 1'b0, resp_active = 1'b0, dly_rand = 1'b0;
  int mptr = 0, n_acc = 0, fixed_dly = 2, eg, d, hold_cnt = 0, last_hold = 0;
  longint load_due = -1, last_lat = 0;
  logic [31:0] ld_n, ld_a, ld_b, last_data, last_init_n;
  logic last_err;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      m_busy = 1'b0;
      resp_active = 1'b0;
      mptr = 0;
      load_due = -1;
      acc_mask = '0;
    end else begin
      chk("busy", busy, m_busy);
      chk("core_r_enable", core_r_enable, cyc == load_due);
      if (cyc == load_due) begin
        chk("core_init_n", core_init_n, ld_n);
        chk("core_init_a", core_init_a, ld_a);
        chk("core_init_b", core_init_b, ld_b);
        last_init_n = core_init_n;
      end
      acc_mask = '0;
      if (m_busy) chk("req_ready_busy", req_ready, 0);
      else if (req_valid == '0) chk("req_ready_idle", req_ready, 0);
      else begin
        eg = rr_pick(req_valid, mptr);
        chk("req_ready_grant", req_ready, onehot(eg));
        dut_glog.push_back(req_ready);
        d = dly_rand ? int'($urandom_range(20, 1)) : fixed_dly;
        delay_cfg = d;
        ld_n = req_n[eg*W +: W];
        ld_a = req_a[eg*W +: W];
        ld_b = req_b[eg*W +: W];
        e.g = eg;
        e.acc = cyc;
        if (d <= TIMEOUT) begin
          e.data = fib(ld_n, ld_a, ld_b);
          e.err = 1'b0;
          e.lat = d + 2;
        end else begin
          e.data = '0;
          e.err = 1'b1;
          e.lat = TIMEOUT + 2;
        end
        exp_q.push_back(e);
        m_busy = 1'b1;
        load_due = cyc + 1;
        acc_mask = onehot(eg);
        n_acc++;
      end
      if (rsp_valid != '0 && !resp_active) begin
        if (exp_q.size() == 0) chk("rsp_unexpected", rsp_valid, 0);
        else begin
          cur = exp_q.pop_front();
          resp_active = 1'b1;
          hold_cnt = 0;
          last_lat = cyc - cur.acc;
          last_data = rsp_data;
          last_err = rsp_err;
          chk("rsp_latency", last_lat, cur.lat);
        end
      end
      if (resp_active) begin
        hold_cnt++;
        chk("rsp_valid", rsp_valid, onehot(cur.g));
        chk("rsp_data", rsp_data, cur.data);
        chk("rsp_err", rsp_err, cur.err);
        if (rsp_ready[cur.g]) begin
          resp_active = 1'b0;
          m_busy = 1'b0;
          mptr = (cur.g + 1) % NREQ;
          last_hold = hold_cnt;
        end
      end
    end
  end

  task automatic set_ops(input int i, input logic [31:0] n, input logic [31:0] a, input logic [31:0] b);
    req_n[i*W +: W] = n;
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
  endtask

  task automatic issue(input logic [NREQ-1:0] m);
    int n0;
    n0 = n_acc;
    req_valid = m;
    for (int k = 0; k < 60 && n_acc == n0; k++) @(posedge clk);
    if (n_acc == n0) tmo("issue_accept");
    #1 req_valid = '0;
  endtask

  task automatic wait_idle(input int limit);
    int k;
    for (k = 0; k < limit; k++) begin
      @(posedge clk);
      if (!m_busy && exp_q.size() == 0) break;
    end
    if (k == limit) tmo("wait_idle");
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_req_ready"}, req_ready, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_data"}, rsp_data, 0);
    chk({tag, "_rsp_err"}, rsp_err, 0);
    chk({tag, "_core_r_enable"}, core_r_enable, 0);
    chk({tag, "_core_init"}, {core_init_n, core_init_a | core_init_b}, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  task automatic run_random(input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) begin
        if (acc_mask[i]) req_valid[i] = 1'b0;
        else if (req_valid[i] && $urandom_range(15) == 0) req_valid[i] = 1'b0;
        else if (!req_valid[i] && $urandom_range(2) == 0) begin
          req_valid[i] = 1'b1;
          set_ops(i, $urandom_range(40), $urandom_range(255), $urandom_range(255));
        end
      end
      rsp_ready = NREQ'($urandom_range(15));
    end
  endtask

  initial begin
    int base, k;
    rst_n = 1'b0;
    req_valid = '0;
    req_n = '0;
    req_a = '0;
    req_b = '0;
    rsp_ready = '1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk_zero("reset");
    @(posedge clk);
    #1;

    // Fairness: all requesters valid back to back.
    for (int i = 0; i < NREQ; i++) set_ops(i, 5 + i, i, 1);
    base = dut_glog.size();
    req_valid = '1;
    for (k = 0; k < 400 && dut_glog.size() < base + 8; k++) @(posedge clk);
    if (k == 400) tmo("fair_accepts");
    #1 req_valid = '0;
    wait_idle(100);
    for (int i = 0; i < 8 && base + i < dut_glog.size(); i++)
      chk($sformatf("fair_grant%0d", i), dut_glog[base + i], onehot(i % NREQ));

    // Single job, fib(10) = 0x37.
    fixed_dly = 5;
    set_ops(0, 10, 0, 1);
    issue(4'b0001);
    wait_idle(100);
    chk("single_data", last_data, 32'h37);
    chk("single_err", last_err, 0);
    chk("single_init_n", last_init_n, 10);
    chk("single_lat", last_lat, 7);

    // Done level left high from the previous job must not finish the next one.
    repeat (3) @(posedge clk);
    #1 fixed_dly = 3;
    set_ops(1, 7, 3, 4);
    issue(4'b0010);
    wait_idle(100);
    chk("stale_lat", last_lat, 5);
    chk("stale_data", last_data, fib(7, 3, 4));

    // Core never finishes.
    fixed_dly = 1000;
    set_ops(3, 9, 1, 1);
    issue(4'b1000);
    wait_idle(100);
    chk("to_err", last_err, 1);
    chk("to_data", last_data, 0);
    chk("to_lat", last_lat, TIMEOUT + 2);

    // Backpressure on requester 2 with others waiting.
    fixed_dly = 2;
    rsp_ready = 4'b1011;
    set_ops(2, 12, 2, 5);
    issue(4'b0100);
    req_valid = 4'b1011;
    for (k = 0; k < 60 && !resp_active; k++) @(posedge clk);
    if (k == 60) tmo("bp_rsp");
    repeat (10) @(posedge clk);
    #1 rsp_ready = '1;
    for (k = 0; k < 60 && m_busy; k++) @(posedge clk);
    if (k == 60) tmo("bp_handshake");
    #1 req_valid = '0;
    wait_idle(100);
    chk("bp_hold", last_hold >= 10, 1);
    chk("bp_data", last_data, fib(12, 2, 5));

    // Reset in the third RUN cycle.
    fixed_dly = 1000;
    issue(4'b0010);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk_zero("rst_run");
    @(posedge clk);
    #1 fixed_dly = 4;
    issue(4'b1111);
    wait_idle(100);
    chk("rst_grant", dut_glog[dut_glog.size() - 1], 4'b0001);
    chk("rst_err", last_err, 0);
    chk("rst_lat", last_lat, 6);

    // Randomized traffic, delays straddling the timeout.
    dly_rand = 1'b1;
    run_random(2500);
    req_valid = '0;
    rsp_ready = '1;
    wait_idle(200);
    chk("queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
endmodule
